// File: rtl/sl_fifo_pkg.sv
// Shared encodings for the outbound 34-bit FIFO word: modifiers, field positions,
// scheduler FSM states and the CHANNEL payload packer.
package sl_fifo_pkg;

  localparam int HMB = 33;
  localparam int LMB = 32;

  localparam logic [1:0] MOD_CONFIG  = 2'd0;
  localparam logic [1:0] MOD_DATA    = 2'd1;
  localparam logic [1:0] MOD_STATUS  = 2'd2;
  localparam logic [1:0] MOD_CHANNEL = 2'd3;

  localparam int CFG_W      = 16;
  localparam int DATA_W     = 32;
  localparam int CH_RX_BIT  = 0;
  localparam int CH_IDX_LSB = 1;

  localparam int ST_IDLE    = 0;
  localparam int ST_SEND_CH = 1;
  localparam int ST_SEND_PL = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'(1 << ST_IDLE),
    SEND_CH = 3'(1 << ST_SEND_CH),
    SEND_PL = 3'(1 << ST_SEND_PL)
  } sched_state_e;

  // Channel index sits above the RX/TX direction bit.
  function automatic logic [DATA_W-1:0] pack_channel(input logic [DATA_W-2:0] idx,
                                                     input logic rx);
    return {idx, rx};
  endfunction

endpackage

// File: rtl/sl_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping at N, returned both one-hot and as an index.
module sl_rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  localparam int SW = PTR_W + 1;

  logic [SW-1:0]    sum;
  logic [PTR_W-1:0] pos;

  // Walk offsets from the pointer; ptr < N so one subtraction handles the wrap.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      pos = sum[PTR_W-1:0];
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/sl_event_scheduler.sv
// Round-robin scheduler funnelling TX/RX channel change events into the outbound
// FIFO as an optional CHANNEL word followed by one payload word per ring visit.
module sl_event_scheduler
  import sl_fifo_pkg::*;
#(
  parameter int TX_COUNT = 1,
  parameter int RX_COUNT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_write_full,
  output logic [33:0]             fifo_write_data,
  output logic                    fifo_write_inc,
  input  logic [TX_COUNT-1:0]     tx_config_changed,
  input  logic [TX_COUNT-1:0]     tx_status_changed,
  input  logic [16*TX_COUNT-1:0]  tx_rd_config,
  input  logic [TX_COUNT-1:0]     tx_rd_status,
  output logic [2*TX_COUNT-1:0]   tx_event_ack,
  input  logic [RX_COUNT-1:0]     rx_config_changed,
  input  logic [RX_COUNT-1:0]     rx_status_changed,
  input  logic [RX_COUNT-1:0]     rx_data_changed,
  input  logic [16*RX_COUNT-1:0]  rx_rd_config,
  input  logic [RX_COUNT-1:0]     rx_rd_status,
  input  logic [32*RX_COUNT-1:0]  rx_rd_data,
  output logic [3*RX_COUNT-1:0]   rx_event_ack
);

  localparam int MAX_CH = (TX_COUNT > RX_COUNT) ? TX_COUNT : RX_COUNT;
  localparam int IDX_W  = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
  localparam int N      = TX_COUNT + RX_COUNT;
  localparam int PTR_W  = $clog2(N);

  logic [N-1:0]     cfg_vec, st_vec, dat_vec, req_vec, flag_vec;
  logic [N-1:0]     pick_oh;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic [1:0]       pick_ev;

  sched_state_e     state_q, state_d;
  logic [PTR_W-1:0] grant_q, grant_d, last_ch_q, last_ch_d, rr_q, rr_d;
  logic [N-1:0]     grant_oh_q, grant_oh_d;
  logic [1:0]       event_q, event_d;
  logic             last_vld_q, last_vld_d;

  logic             live, ack_fire, grant_is_rx;
  logic [IDX_W-1:0] ch_idx;
  logic [31:0]      payload;

  assign cfg_vec = {rx_config_changed, tx_config_changed};
  assign st_vec  = {rx_status_changed, tx_status_changed};
  assign dat_vec = {rx_data_changed, {TX_COUNT{1'b0}}};
  assign req_vec = cfg_vec | st_vec | dat_vec;

  sl_rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
    .req   (req_vec),
    .ptr   (rr_q),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign pick_ev  = (|(pick_oh & dat_vec)) ? MOD_DATA :
                    (|(pick_oh & cfg_vec)) ? MOD_CONFIG : MOD_STATUS;
  assign flag_vec = (event_q == MOD_DATA)   ? dat_vec :
                    (event_q == MOD_CONFIG) ? cfg_vec : st_vec;
  // A flag that drops while granted abandons the payload.
  assign live     = |(grant_oh_q & flag_vec);

  assign grant_is_rx = (grant_q >= PTR_W'(TX_COUNT));
  assign ch_idx      = grant_is_rx ? IDX_W'(grant_q - PTR_W'(TX_COUNT)) : IDX_W'(grant_q);

  always_comb begin
    payload = '0;
    for (int i = 0; i < TX_COUNT; i++) begin
      if (grant_q == PTR_W'(i)) begin
        payload = (event_q == MOD_CONFIG) ? {16'h0, tx_rd_config[16*i +: CFG_W]}
                                          : {31'h0, tx_rd_status[i]};
      end
    end
    for (int i = 0; i < RX_COUNT; i++) begin
      if (grant_q == PTR_W'(TX_COUNT + i)) begin
        if (event_q == MOD_DATA)        payload = rx_rd_data[32*i +: DATA_W];
        else if (event_q == MOD_CONFIG) payload = {16'h0, rx_rd_config[16*i +: CFG_W]};
        else                            payload = {31'h0, rx_rd_status[i]};
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    grant_oh_d      = grant_oh_q;
    event_d         = event_q;
    last_ch_d       = last_ch_q;
    last_vld_d      = last_vld_q;
    rr_d            = rr_q;
    fifo_write_data = '0;
    fifo_write_inc  = 1'b0;
    ack_fire        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          grant_oh_d = pick_oh;
          event_d    = pick_ev;
          state_d    = (!last_vld_q || pick_idx != last_ch_q) ? SEND_CH : SEND_PL;
        end
      end
      SEND_CH: begin
        fifo_write_data[HMB:LMB]   = MOD_CHANNEL;
        fifo_write_data[LMB-1:0]   = pack_channel(31'(ch_idx), grant_is_rx);
        if (!fifo_write_full) begin
          fifo_write_inc = 1'b1;
          last_ch_d      = grant_q;
          last_vld_d     = 1'b1;
          state_d        = SEND_PL;
        end
      end
      SEND_PL: begin
        fifo_write_data[HMB:LMB] = event_q;
        fifo_write_data[LMB-1:0] = payload;
        if (!live) begin
          state_d = IDLE;
        end else if (!fifo_write_full) begin
          fifo_write_inc = 1'b1;
          ack_fire       = 1'b1;
          rr_d           = (grant_q == PTR_W'(N - 1)) ? '0 : grant_q + PTR_W'(1);
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_event_ack = '0;
    rx_event_ack = '0;
    for (int i = 0; i < TX_COUNT; i++) begin
      tx_event_ack[2*i]   = ack_fire & grant_oh_q[i] & (event_q == MOD_CONFIG);
      tx_event_ack[2*i+1] = ack_fire & grant_oh_q[i] & (event_q == MOD_STATUS);
    end
    for (int i = 0; i < RX_COUNT; i++) begin
      rx_event_ack[3*i]   = ack_fire & grant_oh_q[TX_COUNT+i] & (event_q == MOD_DATA);
      rx_event_ack[3*i+1] = ack_fire & grant_oh_q[TX_COUNT+i] & (event_q == MOD_CONFIG);
      rx_event_ack[3*i+2] = ack_fire & grant_oh_q[TX_COUNT+i] & (event_q == MOD_STATUS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_oh_q <= '0;
      event_q    <= MOD_CONFIG;
      last_ch_q  <= '0;
      last_vld_q <= 1'b0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
      event_q    <= event_d;
      last_ch_q  <= last_ch_d;
      last_vld_q <= last_vld_d;
      rr_q       <= rr_d;
    end
  end

endmodule

// File: tb/tb_sl_event_scheduler.sv
// Scoreboard bench for sl_event_scheduler (2 TX + 2 RX): a ring-walk model predicts
// the FIFO word/ack stream for each flag batch; a negedge monitor pops and compares.
module tb_sl_event_scheduler;

  localparam int TXC  = 2;
  localparam int RXC  = 2;
  localparam int NCH  = TXC + RXC;
  localparam int ACKW = 2*TXC + 3*RXC;

  logic                clk = 1'b0;
  logic                rst;
  logic                fifo_write_full;
  logic [33:0]         fifo_write_data;
  logic                fifo_write_inc;
  logic [TXC-1:0]      tx_config_changed, tx_status_changed, tx_rd_status;
  logic [16*TXC-1:0]   tx_rd_config;
  logic [2*TXC-1:0]    tx_event_ack;
  logic [RXC-1:0]      rx_config_changed, rx_status_changed, rx_data_changed, rx_rd_status;
  logic [16*RXC-1:0]   rx_rd_config;
  logic [32*RXC-1:0]   rx_rd_data;
  logic [3*RXC-1:0]    rx_event_ack;

  typedef struct {
    logic [33:0]     data;
    logic [ACKW-1:0] ack;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_rr     = 0;
  int   m_last   = -1;

  always #5 clk = ~clk;

  sl_event_scheduler #(.TX_COUNT(TXC), .RX_COUNT(RXC)) dut (
    .clk               (clk),
    .rst               (rst),
    .fifo_write_full   (fifo_write_full),
    .fifo_write_data   (fifo_write_data),
    .fifo_write_inc    (fifo_write_inc),
    .tx_config_changed (tx_config_changed),
    .tx_status_changed (tx_status_changed),
    .tx_rd_config      (tx_rd_config),
    .tx_rd_status      (tx_rd_status),
    .tx_event_ack      (tx_event_ack),
    .rx_config_changed (rx_config_changed),
    .rx_status_changed (rx_status_changed),
    .rx_data_changed   (rx_data_changed),
    .rx_rd_config      (rx_rd_config),
    .rx_rd_status      (rx_rd_status),
    .rx_rd_data        (rx_rd_data),
    .rx_event_ack      (rx_event_ack)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Channel numbering: 0..TXC-1 are TX, TXC..NCH-1 are RX. Events: 0 config, 1 data, 2 status.
  function automatic logic [33:0] chan_word(input int ch);
    int idx;
    idx = (ch < TXC) ? ch : ch - TXC;
    return {2'd3, 32'(idx * 2 + ((ch >= TXC) ? 1 : 0))};
  endfunction

  function automatic logic [33:0] pay_word(input int ch, input int ev);
    int r;
    r = ch - TXC;
    if (ch < TXC) begin
      if (ev == 0) return {2'd0, 16'h0, tx_rd_config[16*ch +: 16]};
      return {2'd2, 31'h0, tx_rd_status[ch]};
    end
    if (ev == 1) return {2'd1, rx_rd_data[32*r +: 32]};
    if (ev == 0) return {2'd0, 16'h0, rx_rd_config[16*r +: 16]};
    return {2'd2, 31'h0, rx_rd_status[r]};
  endfunction

  // Ack layout as seen on {tx_event_ack, rx_event_ack}.
  function automatic logic [ACKW-1:0] ack_bits(input int ch, input int ev);
    logic [ACKW-1:0] a;
    a = '0;
    if (ch < TXC) a[3*RXC + 2*ch + ((ev == 2) ? 1 : 0)] = 1'b1;
    else          a[3*(ch-TXC) + ((ev == 1) ? 0 : ((ev == 0) ? 1 : 2))] = 1'b1;
    return a;
  endfunction

  // Walk the ring over a snapshot of the pending flags, one event per channel visit.
  task automatic model_batch();
    logic [TXC-1:0] tc, ts;
    logic [RXC-1:0] rd, rc, rs;
    int ch, ev, guard;
    tc = tx_config_changed; ts = tx_status_changed;
    rd = rx_data_changed;   rc = rx_config_changed; rs = rx_status_changed;
    guard = 0;
    while ((|{tc, ts, rd, rc, rs}) && guard < 64) begin
      ch = -1;
      ev = 0;
      for (int k = 0; k < NCH; k++) begin
        int c;
        bit p;
        c = (m_rr + k) % NCH;
        if (c < TXC) p = tc[c] | ts[c];
        else         p = rd[c-TXC] | rc[c-TXC] | rs[c-TXC];
        if (ch < 0 && p) ch = c;
      end
      if (ch < TXC) begin
        if (tc[ch]) begin ev = 0; tc[ch] = 1'b0; end
        else        begin ev = 2; ts[ch] = 1'b0; end
      end else begin
        if (rd[ch-TXC])      begin ev = 1; rd[ch-TXC] = 1'b0; end
        else if (rc[ch-TXC]) begin ev = 0; rc[ch-TXC] = 1'b0; end
        else                 begin ev = 2; rs[ch-TXC] = 1'b0; end
      end
      if (ch != m_last) exp_q.push_back('{chan_word(ch), '0});
      exp_q.push_back('{pay_word(ch, ev), ack_bits(ch, ev)});
      m_last = ch;
      m_rr   = (ch + 1) % NCH;
      guard++;
    end
  endtask

  task automatic applyStimulus(input logic [TXC-1:0] tc, input logic [TXC-1:0] ts,
                               input logic [RXC-1:0] rd, input logic [RXC-1:0] rc,
                               input logic [RXC-1:0] rs);
    @(posedge clk); #1;
    tx_config_changed = tx_config_changed | tc;
    tx_status_changed = tx_status_changed | ts;
    rx_data_changed   = rx_data_changed   | rd;
    rx_config_changed = rx_config_changed | rc;
    rx_status_changed = rx_status_changed | rs;
    model_batch();
  endtask

  // Channel side: a flag clears on the clock edge that ends its ack pulse.
  task automatic drain(input int max_cycles, input bit rand_full);
    int cyc;
    logic [2*TXC-1:0] tcap;
    logic [3*RXC-1:0] rcap;
    cyc = 0;
    while ((|{tx_config_changed, tx_status_changed, rx_data_changed,
              rx_config_changed, rx_status_changed}) && cyc < max_cycles) begin
      @(negedge clk);
      tcap = tx_event_ack;
      rcap = rx_event_ack;
      @(posedge clk); #1;
      for (int i = 0; i < TXC; i++) begin
        if (tcap[2*i])   tx_config_changed[i] = 1'b0;
        if (tcap[2*i+1]) tx_status_changed[i] = 1'b0;
      end
      for (int i = 0; i < RXC; i++) begin
        if (rcap[3*i])   rx_data_changed[i]   = 1'b0;
        if (rcap[3*i+1]) rx_config_changed[i] = 1'b0;
        if (rcap[3*i+2]) rx_status_changed[i] = 1'b0;
      end
      fifo_write_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
      cyc++;
    end
    fifo_write_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("drain_in_time", 64'(cyc < max_cycles), 64'd1);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    tx_config_changed = '0; tx_status_changed = '0;
    rx_data_changed = '0; rx_config_changed = '0; rx_status_changed = '0;
  endtask

  // Monitor: every accepted FIFO write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (fifo_write_inc === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write_count", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("write_data", 64'(fifo_write_data), 64'(mon_e.data));
          checkOutput("write_ack", 64'({tx_event_ack, rx_event_ack}), 64'(mon_e.ack));
        end
      end else if (|{tx_event_ack, rx_event_ack}) begin
        checkOutput("ack_without_write", 64'({tx_event_ack, rx_event_ack}), 64'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    fifo_write_full = 1'b0;
    tx_config_changed = '0; tx_status_changed = '0; tx_rd_status = '0; tx_rd_config = '0;
    rx_config_changed = '0; rx_status_changed = '0; rx_data_changed = '0;
    rx_rd_status = '0; rx_rd_config = '0; rx_rd_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    repeat (20) begin
      @(negedge clk);
      checkOutput("idle_outputs", 64'({fifo_write_inc, tx_event_ack, rx_event_ack, fifo_write_data}), 64'd0);
    end

    // Every flag set from a fresh ring: CHANNEL 0x0, 0x2, 0x1, 0x3, then the ring repeats.
    tx_rd_config = 32'($urandom); rx_rd_config = 32'($urandom);
    rx_rd_data = {$urandom, $urandom}; tx_rd_status = 2'b10; rx_rd_status = 2'b01;
    applyStimulus('1, '1, '1, '1, '1);
    drain(200, 1'b0);

    tx_rd_config[15:0] = 16'hA5C3;
    applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    drain(50, 1'b0);

    tx_rd_status[0] = 1'b1;
    applyStimulus(2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    drain(50, 1'b0);

    rx_rd_data[31:0] = 32'hDEADBEEF;
    rx_rd_config[15:0] = 16'h0042;
    applyStimulus(2'b00, 2'b00, 2'b01, 2'b01, 2'b00);
    drain(50, 1'b0);

    // Same channel again with the FIFO full: payload must sit stable with no strobe.
    rx_rd_status[0] = 1'b1;
    fifo_write_full = 1'b1;
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      checkOutput("full_hold_inc", 64'(fifo_write_inc), 64'd0);
      checkOutput("full_hold_data", 64'(fifo_write_data), 64'(exp_q[0].data));
    end
    @(posedge clk); #1;
    fifo_write_full = 1'b0;
    drain(50, 1'b0);

    // Flag withdrawn after grant: CHANNEL word still goes out, payload and ack do not.
    fifo_write_full = 1'b1;
    @(posedge clk); #1;
    tx_status_changed[1] = 1'b1;
    exp_q.push_back('{chan_word(1), '0});
    m_last = 1;
    repeat (3) @(posedge clk);
    #1;
    tx_status_changed[1] = 1'b0;
    fifo_write_full = 1'b0;
    drain(20, 1'b0);

    // Reset while a payload is pending forgets last channel, so CHANNEL is resent.
    fifo_write_full = 1'b1;
    tx_rd_config[31:16] = 16'($urandom);
    @(posedge clk); #1;
    tx_config_changed[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("payload_before_reset", 64'(fifo_write_data), 64'(pay_word(1, 0)));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_mid_outputs", 64'({fifo_write_inc, tx_event_ack, rx_event_ack, fifo_write_data}), 64'd0);
    rst = 1'b0;
    fifo_write_full = 1'b0;
    m_rr = 0;
    m_last = -1;
    model_batch();
    drain(50, 1'b0);

    for (int b = 0; b < 40; b++) begin
      tx_rd_config = 32'($urandom); rx_rd_config = 32'($urandom);
      rx_rd_data = {$urandom, $urandom};
      tx_rd_status = 2'($urandom); rx_rd_status = 2'($urandom);
      applyStimulus(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      drain(300, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
